// File: rtl/mem_responder.sv
// mem_responder: byte-addressed backing store plus a small register window
// for a soft core. The store is filled by a byte-serial loader while the
// core is held in reset; once the final byte lands the core is released and
// serves word reads/writes at any byte alignment.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_LOAD | loader fills memory at ptr, core held in reset
// ST_RUN  | core released, core stores accepted, CYCLES counting
module mem_responder #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        write_enable,
  output logic [31:0] rdata,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        core_rst,
  output logic [7:0]  led,
  output logic        fault
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [31:0] OFF_LED    = 32'd0;
  localparam logic [31:0] OFF_CYCLES = 32'd4;
  localparam logic [31:0] OFF_STATUS = 32'd8;

  logic [0:0]    state;
  logic [AW-1:0] ptr;
  logic [31:0]   cycles;
  logic [7:0]    mem [MEM_BYTES];

  logic          run;
  logic          in_mem;
  logic          in_mmio;
  logic          out_of_range;
  logic [31:0]   mmio_off;
  logic [AW-1:0] base_idx;
  logic          load_wr;
  logic          core_wr;

  assign run          = (state == ST_RUN);
  assign in_mem       = (address < 32'(MEM_BYTES));
  assign in_mmio      = (address >= MMIO_BASE);
  assign out_of_range = !in_mem && !in_mmio;
  assign mmio_off     = address - MMIO_BASE;
  // Low address bits give the modulo-MEM_BYTES index, so words that run
  // past the top of the store wrap to byte 0 for free.
  assign base_idx     = address[AW-1:0];
  assign load_wr      = !run && load_valid;
  assign core_wr      = run && write_enable && in_mem;

  // Combinational little-endian read of memory or the register window.
  always_comb begin
    rdata = '0;
    if (in_mem) begin
      for (int i = 0; i < 4; i++) begin
        rdata[8*i +: 8] = mem[base_idx + AW'(i)];
      end
    end else if (in_mmio) begin
      case (mmio_off)
        OFF_LED:    rdata = {24'b0, led};
        OFF_CYCLES: rdata = cycles;
        OFF_STATUS: rdata = {30'b0, run, fault};
        default:    rdata = '0;
      endcase
    end
  end

  // Memory writes from loader or core; the array keeps its contents over
  // reset, but no write happens on an edge while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (load_wr) begin
      mem[ptr] <= load_byte;
    end else if (core_wr) begin
      for (int i = 0; i < 4; i++) begin
        mem[base_idx + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // Sequencer, load pointer, LED register, cycle counter and sticky fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_LOAD;
      core_rst <= 1'b1;
      ptr      <= '0;
      led      <= '0;
      fault    <= 1'b0;
      cycles   <= '0;
    end else if (!run) begin
      if (load_valid) begin
        ptr <= ptr + 1'b1;
        if (load_last) begin
          state    <= ST_RUN;
          core_rst <= 1'b0;
        end
      end
    end else begin
      cycles <= cycles + 32'd1;
      // Any access between the store and the register window is a fault,
      // whether the core is reading or writing.
      if (out_of_range) begin
        fault <= 1'b1;
      end
      if (write_enable && address == MMIO_BASE) begin
        led <= wdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a 64-byte store.
module tb_mem_responder;

  localparam int          MB   = 64;
  localparam logic [31:0] MMIO = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic        write_enable = 1'b0;
  logic [31:0] rdata;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_last = 1'b0;
  logic        core_rst;
  logic [7:0]  led;
  logic        fault;

  int vectors = 0;
  int miscompares = 0;

  mem_responder #(.MEM_BYTES(MB), .MMIO_BASE(MMIO)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .wdata        (wdata),
    .write_enable (write_enable),
    .rdata        (rdata),
    .load_valid   (load_valid),
    .load_byte    (load_byte),
    .load_last    (load_last),
    .core_rst     (core_rst),
    .led          (led),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (core_rst !== 1'b1) begin
      miscompares++; $display("FAIL reset_core_rst: got %b expected 1", core_rst);
    end
    vectors++;
    if (led !== 8'h00) begin
      miscompares++; $display("FAIL reset_led: got %h expected 00", led);
    end
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++; $display("FAIL reset_fault: got %b expected 0", fault);
    end
    address = MMIO + 32'd8;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_status: got %h expected 00000000", rdata);
    end
  endtask

  task automatic test_load_basic();
    address = 32'd0;
    rst = 1'b1;
    tick();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    vectors++;
    if (core_rst !== 1'b1) begin
      miscompares++; $display("FAIL load_core_rst_held: got %b expected 1", core_rst);
    end
    send_byte(8'h55, 1'b1);
    vectors++;
    if (core_rst !== 1'b0) begin
      miscompares++; $display("FAIL load_core_rst_release: got %b expected 0", core_rst);
    end
    address = 32'd1;
    #1;
    vectors++;
    if (rdata !== 32'h55443322) begin
      miscompares++; $display("FAIL load_read_addr1: got %h expected 55443322", rdata);
    end
    address = MMIO + 32'd4;
    #1;
    vectors++;
    if (rdata !== 32'd0) begin
      miscompares++; $display("FAIL cycles_start: got %h expected 00000000", rdata);
    end
    tick();
    tick();
    tick();
    vectors++;
    if (rdata !== 32'd3) begin
      miscompares++; $display("FAIL cycles_count: got %h expected 00000003", rdata);
    end
    address = MMIO + 32'd8;
    #1;
    vectors++;
    if (rdata !== 32'h2) begin
      miscompares++; $display("FAIL status_run: got %h expected 00000002", rdata);
    end
  endtask

  task automatic test_write_wrap();
    address = 32'd0;
    wdata = 32'hCAFEF00D;
    write_enable = 1'b1;
    #1;
    vectors++;
    if (rdata !== 32'h44332211) begin
      miscompares++; $display("FAIL write_prewrite: got %h expected 44332211", rdata);
    end
    tick();
    write_enable = 1'b0;
    #1;
    vectors++;
    if (rdata !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL write_postwrite: got %h expected cafef00d", rdata);
    end
    address = MB - 2;
    wdata = 32'hDEADBEEF;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    #1;
    vectors++;
    if (rdata !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL wrap_read_top: got %h expected deadbeef", rdata);
    end
    address = 32'd0;
    #1;
    vectors++;
    if (rdata !== 32'hCAFEDEAD) begin
      miscompares++; $display("FAIL wrap_read_low: got %h expected cafedead", rdata);
    end
    address = MB - 1;
    #1;
    vectors++;
    if (rdata !== 32'hFEDEADBE) begin
      miscompares++; $display("FAIL wrap_read_last: got %h expected fedeadbe", rdata);
    end
  endtask

  task automatic test_led();
    address = MMIO;
    wdata = 32'h000001A5;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    #1;
    vectors++;
    if (led !== 8'hA5) begin
      miscompares++; $display("FAIL led_write: got %h expected a5", led);
    end
    vectors++;
    if (rdata !== 32'h000000A5) begin
      miscompares++; $display("FAIL led_read: got %h expected 000000a5", rdata);
    end
    address = MMIO + 32'd2;
    wdata = 32'hFFFFFFFF;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    #1;
    vectors++;
    if (led !== 8'hA5) begin
      miscompares++; $display("FAIL led_unaligned_write: got %h expected a5", led);
    end
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL mmio_unmapped_read: got %h expected 00000000", rdata);
    end
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++; $display("FAIL mmio_unmapped_fault: got %b expected 0", fault);
    end
  endtask

  task automatic test_fault();
    address = 32'h0001_0000;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL oob_read: got %h expected 00000000", rdata);
    end
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++; $display("FAIL oob_fault_early: got %b expected 0", fault);
    end
    tick();
    vectors++;
    if (fault !== 1'b1) begin
      miscompares++; $display("FAIL oob_fault_set: got %b expected 1", fault);
    end
    address = MMIO + 32'd8;
    #1;
    vectors++;
    if (rdata !== 32'h3) begin
      miscompares++; $display("FAIL status_fault: got %h expected 00000003", rdata);
    end
    address = MB;
    wdata = 32'h99999999;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    address = 32'd0;
    tick();
    vectors++;
    if (rdata !== 32'hCAFEDEAD) begin
      miscompares++; $display("FAIL oob_write_discard: got %h expected cafedead", rdata);
    end
    vectors++;
    if (fault !== 1'b1) begin
      miscompares++; $display("FAIL fault_sticky: got %b expected 1", fault);
    end
  endtask

  task automatic test_reset_midload();
    address = 32'd0;
    wdata = 32'h12345678;
    write_enable = 1'b1;
    rst = 1'b0;
    #1;
    vectors++;
    if (core_rst !== 1'b1) begin
      miscompares++; $display("FAIL async_core_rst: got %b expected 1", core_rst);
    end
    vectors++;
    if (fault !== 1'b0 || led !== 8'h00) begin
      miscompares++; $display("FAIL async_clear: got fault=%b led=%h expected fault=0 led=00", fault, led);
    end
    address = MMIO + 32'd4;
    #1;
    vectors++;
    if (rdata !== 32'd0) begin
      miscompares++; $display("FAIL reset_cycles: got %h expected 00000000", rdata);
    end
    tick();
    write_enable = 1'b0;
    rst = 1'b1;
    address = 32'd0;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    rst = 1'b0;
    tick();
    vectors++;
    if (core_rst !== 1'b1) begin
      miscompares++; $display("FAIL midload_core_rst: got %b expected 1", core_rst);
    end
    rst = 1'b1;
    send_byte(8'h77, 1'b0);
    send_byte(8'hB8, 1'b1);
    #1;
    vectors++;
    if (rdata !== 32'hCAA3B877) begin
      miscompares++; $display("FAIL midload_restart: got %h expected caa3b877", rdata);
    end
  endtask

  task automatic test_wrap_load();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    address = 32'd0;
    for (int k = 0; k < MB; k++) begin
      send_byte(8'(k), 1'b0);
    end
    vectors++;
    if (core_rst !== 1'b1) begin
      miscompares++; $display("FAIL wrapload_held: got %b expected 1", core_rst);
    end
    send_byte(8'hAA, 1'b1);
    #1;
    vectors++;
    if (rdata !== 32'h030201AA) begin
      miscompares++; $display("FAIL wrapload_low: got %h expected 030201aa", rdata);
    end
    address = MB - 1;
    #1;
    vectors++;
    if (rdata !== 32'h0201AA3F) begin
      miscompares++; $display("FAIL wrapload_top: got %h expected 0201aa3f", rdata);
    end
    vectors++;
    if (core_rst !== 1'b0) begin
      miscompares++; $display("FAIL wrapload_release: got %b expected 0", core_rst);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_write_wrap();
    test_led();
    test_fault();
    test_reset_midload();
    test_wrap_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
